// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: per-digit load, 1 Hz decrement with BCD borrow,
// and an expiry flag plus blinking alarm when the value reaches 00:00.

module countdown_digit #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr,
    input  logic [3:0] wr_val,
    input  logic       dec,
    output logic [3:0] digit
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            digit <= 4'd0;
        else if (clr)
            digit <= 4'd0;
        else if (wr)
            digit <= (wr_val > LIMIT) ? LIMIT : wr_val;
        else if (dec)
            digit <= (digit == 4'd0) ? LIMIT : digit - 4'd1;
    end
endmodule

module countdown_timer #(
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       clear,
    input  logic       set_en,
    input  logic [1:0] sel,
    input  logic [3:0] num,
    output logic [3:0] min_l,
    output logic [3:0] min_r,
    output logic [3:0] sec_l,
    output logic [3:0] sec_r,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    localparam int NUM_DIGITS = 4;
    localparam logic [7:0] ALARM_LIM = 8'(ALARM_TICKS);
    // Index 0 is sec_r, index 3 is min_l; the borrow ripples upward.
    localparam logic [NUM_DIGITS-1:0][3:0] LIMITS = {4'd9, 4'd9, 4'd5, 4'd9};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dec_in;
    logic [NUM_DIGITS-1:0]      wr_sel;
    logic [1:0]                 wr_idx;
    logic dig_clr, dig_wr, dig_dec;
    logic [7:0] acnt_q, acnt_d;
    logic alarm_q, alarm_d;
    logic running_q, done_q;
    logic is_zero, at_one;

    assign wr_idx  = 2'd3 - sel;
    assign is_zero = (dig == '0);
    assign at_one  = (dig == {4'd0, 4'd0, 4'd0, 4'd1});
    assign dec_in[0] = dig_dec;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
            if (i > 0) begin : g_borrow
                assign dec_in[i] = dec_in[i-1] && (dig[i-1] == 4'd0);
            end
            assign wr_sel[i] = dig_wr && (wr_idx == 2'(i));
            countdown_digit #(.LIMIT(LIMITS[i])) u_digit (
                .clk    (clk),
                .rst    (rst),
                .clr    (dig_clr),
                .wr     (wr_sel[i]),
                .wr_val (num),
                .dec    (dec_in[i]),
                .digit  (dig[i])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        dig_clr = 1'b0;
        dig_wr  = 1'b0;
        dig_dec = 1'b0;
        acnt_d  = acnt_q;
        alarm_d = alarm_q;
        if (clear) begin
            state_d = IDLE;
            dig_clr = 1'b1;
            acnt_d  = 8'd0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!is_zero)
                            state_d = RUN;
                    end else if (set_en) begin
                        dig_wr = 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        dig_dec = 1'b1;
                        // Only 00:01 can decrement into 00:00.
                        if (at_one) begin
                            state_d = EXPIRED;
                            acnt_d  = 8'd0;
                            alarm_d = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start)
                        state_d = RUN;
                end
                EXPIRED: begin
                    if (start) begin
                        state_d = IDLE;
                        dig_clr = 1'b1;
                        acnt_d  = 8'd0;
                        alarm_d = 1'b0;
                    end else if (tick && acnt_q < ALARM_LIM) begin
                        acnt_d  = acnt_q + 8'd1;
                        alarm_d = (acnt_q + 8'd1 == ALARM_LIM) ? 1'b0 : ~alarm_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            acnt_q    <= 8'd0;
            alarm_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            alarm_q   <= alarm_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == EXPIRED);
        end
    end

    assign min_l   = dig[3];
    assign min_r   = dig[2];
    assign sec_l   = dig[1];
    assign sec_r   = dig[0];
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios then random pulses, checked
// against a model that keeps the timer value as a plain count of seconds.

module tb_countdown_timer;
    localparam int AT = 4;

    logic clk = 0, rst = 0;
    logic tick = 0, start = 0, clear = 0, set_en = 0;
    logic [1:0] sel = 0;
    logic [3:0] num = 0;
    logic [3:0] min_l, min_r, sec_l, sec_r;
    logic running, done, alarm;

    int checks = 0, errors = 0;
    // model: mode 0 idle, 1 run, 2 pause, 3 expired
    int m_secs = 0, m_mode = 0, m_aseen = 0;

    countdown_timer #(.ALARM_TICKS(AT)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .clear(clear),
        .set_en(set_en), .sel(sel), .num(num),
        .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int put_digit(input int secs, input int s, input int n);
        int d[4];
        int lim;
        d[0] = secs / 600;
        d[1] = (secs / 60) % 10;
        d[2] = (secs % 60) / 10;
        d[3] = secs % 10;
        lim = (s == 2) ? 5 : 9;
        d[s] = (n > lim) ? lim : n;
        return (d[0] * 10 + d[1]) * 60 + d[2] * 10 + d[3];
    endfunction

    task automatic model_reset();
        m_secs = 0; m_mode = 0; m_aseen = 0;
    endtask

    task automatic model_step(input bit c, input bit st, input bit se,
                              input int s, input int n, input bit tk);
        if (c) begin
            model_reset();
        end else if (st) begin
            case (m_mode)
                0: if (m_secs != 0) m_mode = 1;
                1: m_mode = 2;
                2: m_mode = 1;
                default: model_reset();
            endcase
        end else if (se && m_mode == 0) begin
            m_secs = put_digit(m_secs, s, n);
        end else if (tk) begin
            if (m_mode == 1) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_mode = 3;
                    m_aseen = 0;
                end
            end else if (m_mode == 3 && m_aseen < AT) begin
                m_aseen++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int exp_alarm;
        exp_alarm = (m_mode == 3 && m_aseen < AT && (m_aseen % 2) == 0) ? 1 : 0;
        chk({tag, ".min_l"}, min_l, m_secs / 600);
        chk({tag, ".min_r"}, min_r, (m_secs / 60) % 10);
        chk({tag, ".sec_l"}, sec_l, (m_secs % 60) / 10);
        chk({tag, ".sec_r"}, sec_r, m_secs % 10);
        chk({tag, ".running"}, running, (m_mode == 1) ? 1 : 0);
        chk({tag, ".done"}, done, (m_mode == 3) ? 1 : 0);
        chk({tag, ".alarm"}, alarm, exp_alarm);
    endtask

    // One clock: drive pulses, sample at the edge, check 1 time unit later.
    task automatic cyc(input string tag, input bit c, input bit st, input bit se,
                       input int s, input int n, input bit tk);
        clear = c; start = st; set_en = se; sel = 2'(s); num = 4'(n); tick = tk;
        @(posedge clk);
        model_step(c, st, se, s, n, tk);
        #1;
        clear = 0; start = 0; set_en = 0; tick = 0;
        check_model(tag);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        cyc("ld0", 0, 0, 1, 0, a, 0);
        cyc("ld1", 0, 0, 1, 1, b, 0);
        cyc("ld2", 0, 0, 1, 2, c, 0);
        cyc("ld3", 0, 0, 1, 3, d, 0);
    endtask

    initial begin
        int alarm_seq[4];
        alarm_seq = '{0, 1, 0, 0};
        #2;
        model_reset();
        check_model("reset");
        #10 rst = 1;

        // digit writes with clamping
        cyc("t1a", 0, 0, 1, 2, 7, 0);
        cyc("t1b", 0, 0, 1, 3, 3, 0);
        chk("t1.sec_l_clamp", sec_l, 5);
        chk("t1.sec_r", sec_r, 3);

        // 10:00 -> 09:59
        load(1, 0, 0, 0);
        cyc("t2s", 0, 1, 0, 0, 0, 0);
        cyc("t2t", 0, 0, 0, 0, 0, 1);
        chk("t2.min_r", min_r, 9);
        chk("t2.sec_l", sec_l, 5);
        chk("t2.sec_r", sec_r, 9);
        chk("t2.running", running, 1);

        // expiry and alarm blink
        cyc("t3c", 1, 0, 0, 0, 0, 0);
        load(0, 0, 0, 2);
        cyc("t3s", 0, 1, 0, 0, 0, 0);
        cyc("t3t1", 0, 0, 0, 0, 0, 1);
        chk("t3.sec_r1", sec_r, 1);
        cyc("t3t2", 0, 0, 0, 0, 0, 1);
        chk("t3.done", done, 1);
        chk("t3.alarm_entry", alarm, 1);
        for (int k = 0; k < 4; k++) begin
            cyc("t3a", 0, 0, 0, 0, 0, 1);
            chk("t3.alarm_seq", alarm, alarm_seq[k]);
        end
        chk("t3.done_held", done, 1);
        cyc("t3x", 0, 1, 0, 0, 0, 0);
        chk("t3.done_exit", done, 0);

        // pause with simultaneous tick, resume
        load(0, 5, 3, 0);
        cyc("t4s", 0, 1, 0, 0, 0, 0);
        cyc("t4p", 0, 1, 0, 0, 0, 1);
        chk("t4.paused", running, 0);
        chk("t4.sec_l", sec_l, 3);
        cyc("t4i1", 0, 0, 0, 0, 0, 1);
        cyc("t4i2", 0, 0, 1, 1, 8, 1);
        chk("t4.frozen", sec_r, 0);
        cyc("t4r", 0, 1, 0, 0, 0, 0);
        cyc("t4t", 0, 0, 0, 0, 0, 1);
        chk("t4.sec_l_29", sec_l, 2);
        chk("t4.sec_r_29", sec_r, 9);

        // start on 00:00 ignored; clear during pause
        cyc("t5c", 1, 0, 0, 0, 0, 0);
        cyc("t5s", 0, 1, 0, 0, 0, 0);
        chk("t5.zero_start", running, 0);
        load(0, 3, 1, 5);
        cyc("t5r", 0, 1, 0, 0, 0, 0);
        cyc("t5p", 0, 1, 0, 0, 0, 0);
        cyc("t5x", 1, 0, 0, 0, 0, 0);
        chk("t5.cleared", min_r, 0);

        // asynchronous reset mid-run
        load(0, 1, 0, 0);
        cyc("t6s", 0, 1, 0, 0, 0, 0);
        #2 rst = 0;
        #1;
        model_reset();
        chk("t6.async_min_r", min_r, 0);
        chk("t6.async_running", running, 0);
        @(negedge clk);
        rst = 1;
        for (int k = 0; k < 3; k++) cyc("t6t", 0, 0, 0, 0, 0, 1);

        // random pulses
        for (int k = 0; k < 1500; k++) begin
            bit c, st, se, tk;
            int s, n;
            c  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 7);
            tk = ($urandom_range(0, 99) < 50);
            se = !tk && ($urandom_range(0, 99) < 30);
            s  = $urandom_range(0, 3);
            n  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            cyc("rnd", c, st, se, s, n, tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Count-down counterpart to the stopwatch counter. It holds an MM:SS value in four BCD digits that the user loads one digit at a time, then decrements it once per 1 Hz tick. On reaching 00:00 it raises an expiry flag and a blinking alarm. It sits between the clock divider and debounced buttons on one side and the 7-segment display on the other, and presents the same digit outputs as the stopwatch counter so the display needs no change.

## Interface
- ALARM_TICKS, 10: number of ticks the alarm output blinks after expiry; range 1..255.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  1 Hz enable, one clk cycle wide, synchronous to clk.
- start  in  1  debounced start/pause pulse, one cycle wide.
- clear  in  1  debounced clear pulse, one cycle wide.
- set_en  in  1  digit write strobe, one cycle wide.
- sel  in  2  digit select for writes: 0=min_l, 1=min_r, 2=sec_l, 3=sec_r.
- num  in  4  BCD value to write.
- min_l, min_r, sec_l, sec_r  out  4 each  current BCD digits, registered.
- running  out  1  high in RUN state.
- done  out  1  high in EXPIRED state.
- alarm  out  1  blinking alarm, registered.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset: state IDLE; all digits 0; running, done and alarm all 0; alarm tick count 0.
- Input priority in a single cycle: clear > start > set_en > tick.
- IDLE:
  - set_en writes num into the selected digit.
  - Values above the digit limit are clamped to the limit: 9 for min_l, min_r and sec_r; 5 for sec_l.
  - start goes to RUN if the value is not 00:00; otherwise start is ignored.
  - tick is ignored.
- RUN:
  - tick decrements the value by one second using BCD borrow. sec_r 0 becomes 9 and borrows from sec_l; sec_l 0 becomes 5 and borrows from min_r; min_r 0 becomes 9 and borrows from min_l.
  - If the decremented value is 00:00, the next state is EXPIRED.
  - start goes to PAUSE; any tick in the same cycle is dropped.
  - clear goes to IDLE and zeroes all digits.
  - set_en is ignored.
- PAUSE:
  - Digits are frozen; tick and set_en are ignored.
  - start goes to RUN.
  - clear goes to IDLE and zeroes all digits.
- EXPIRED:
  - done is 1 and digits hold 00:00.
  - alarm is set to 1 on entry and toggles on each tick until ALARM_TICKS ticks have been seen in EXPIRED. It is then held at 0 while done stays 1.
  - start or clear goes to IDLE with digits 00:00, and done and alarm both cleared.
- running is 1 only in RUN. done is 1 only in EXPIRED.
- The value never wraps below 00:00. The maximum value is 99:59.

## Timing
- All outputs are registered and change only on a rising clk edge or on rst assertion.
- Digit update latency is 1 cycle: a tick sampled at edge N gives the new digits after edge N.
- EXPIRED entry: done and alarm go to 1 on the same edge at which the digits become 00:00.
- State transitions caused by start or clear take effect on the sampling edge, so running and done change 1 cycle after the pulse is sampled.
- Any set_en write is visible on the digit outputs the cycle after the strobe.
- An rst assertion mid-count forces IDLE and 00:00 immediately, with no clk edge needed. Release is sampled on the next edge.
- Inputs held high longer than one cycle act once per cycle they are high; edge detection is the debouncer's job.

## Test plan
- Reset, write sel=2 num=7 and sel=3 num=3 -> sec_l=5 (clamped), sec_r=3; display reads 00:53.
- Load 10:00, start, one tick -> 09:59 one cycle after the tick, running=1.
- Load 00:02, start, two ticks -> 00:01, then 00:00 with done=1 and alarm=1 on the same edge. With ALARM_TICKS=4, alarm reads 0,1,0,then held 0 after four further ticks; done remains 1.
- In RUN at 05:30, assert start and tick in the same cycle -> PAUSE, digits stay 05:30. Further ticks leave 05:30. start resumes, and the next tick gives 05:29.
- start with 00:00 loaded -> remains IDLE, running=0. clear during PAUSE at 03:15 -> IDLE, 00:00.
- Assert rst asynchronously mid-RUN at 01:00 between clk edges -> digits immediately 0 and running=0; after release, ticks leave the digits unchanged.
